pcm_rx: RTL and testbench
=========================

Name: pcm_rx

Overview:
- Serial PCM (I2S-format) audio receiver. It is the receiving end of the lrck/bck/adata link driven by the sine PCM generator in verif.
- Oversamples bck, lrck and adata on the system clock scki, deserializes left and right words MSB-first, and presents one stereo pair per frame with a single-cycle valid strobe.
- Used in the verif loopback and as the ADC-side front end of the DSP path.

Parameters:
- WIDTH, 16, sample width in bits per channel.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2).
- TIMEOUT, 64, scki cycles without a bck rising edge before lock is dropped.

Ports:
- scki  in  1  system clock; all logic is on its rising edge. Frequency must be at least 4x bck.
- rst_n  in  1  asynchronous active-low reset.
- bck  in  1  serial bit clock, asynchronous to scki.
- lrck  in  1  word select, asynchronous to scki; 0 = left, 1 = right.
- adata  in  1  serial data; changes on bck falling edge, MSB first.
- left_data  out  WIDTH  last complete left sample.
- right_data  out  WIDTH  last complete right sample.
- valid  out  1  one-scki pulse when left_data and right_data are updated together.
- short_err  out  1  one-scki pulse when a committed word had fewer than WIDTH bits.
- locked  out  1  high while aligned to frames.

Behaviour:
- Reset (rst_n low, async):
  - left_data, right_data = 0; valid, short_err, locked = 0.
  - State = IDLE; shift register, bit count, left-hold register and left_ok = 0; timeout counter = 0.
- Input capture:
  - bck, lrck and adata each pass through SYNC_STAGES flops.
  - bck_rise = sync_bck & ~bck_prev; it is the only sampling event.
  - On bck_rise, capture lrck_s and adata_s; lrck_last holds the lrck captured at the previous bck_rise.
- Boundary: a bck_rise where lrck_s != lrck_last. The adata bit at a boundary edge is the LSB of the outgoing channel (I2S one-bit delay). The next bck_rise carries the MSB of the new channel.
- States:
  - IDLE: track lrck_last only; no shifting. On the first boundary, go to RUN, clear the shift register and count, clear left_ok, set locked = 1. The bit at that edge is discarded.
  - RUN, each non-boundary bck_rise: if count < WIDTH, write adata_s to shreg[WIDTH-1-count] and count++. Bits beyond WIDTH are ignored and count saturates.
  - RUN, boundary bck_rise: first apply the same write rule to form the outgoing word, then commit it:
    - lrck 0->1 (left done): left-hold = word; left_ok = 1.
    - lrck 1->0 (right done): if left_ok, left_data = left-hold, right_data = word, valid = 1 for one cycle; left_ok = 0.
    - In both cases, short_err = 1 for one cycle if pre-write count + 1 < WIDTH. Short words are left-justified and zero-filled in the LSBs.
    - Then clear shreg and count.
- Timeout: the counter increments each scki cycle and resets on bck_rise. When it reaches TIMEOUT: go to IDLE, locked = 0, left_ok = 0. Outputs hold their last values.
- Latency: valid asserts exactly SYNC_STAGES+2 scki cycles after the first scki edge that samples the input bck high on the boundary edge.
- An lrck change with no bck edge has no effect until the next bck_rise.
- Simultaneous timeout expiry and bck_rise in the same cycle: bck_rise wins and the counter clears.
- A first boundary of 0->1 (entering right) produces no valid at the following right commit, because left_ok is 0.
- Reset mid-frame aborts immediately: any partial word is discarded and resync waits for a new boundary.

Test Plan:
- WIDTH=16, 32 bck per frame, scki = 8x bck; send L=16'hA5C3, R=16'h1234 for 3 frames -> valid pulses once per frame; left_data=A5C3, right_data=1234 at each pulse; short_err never asserts.
- Start the stream mid right-channel, then send L=16'h8001, R=16'h7FFE -> the first partial frame produces no valid; the first valid carries 8001/7FFE; locked rises at the first lrck change.
- 12 bits per channel slot, L=12'hFFF, R=12'h001 -> left_data=16'hFFF0, right_data=16'h0010; short_err pulses on each commit.
- 24 bits per channel, L=24'hABCDEF -> left_data=16'hABCD; extra bits ignored; no short_err.
- Stop bck for 70 scki cycles mid-word -> locked falls at cycle 64; no valid; data outputs hold; on restart, outputs re-lock and deliver correct data from the first full L/R pair.
- Assert rst_n low mid right-word -> all outputs go to 0 immediately; after release, the first valid occurs only after a new boundary plus a full left and right pair.

Source files
------------

// File: rtl/pcm_rx.sv
// I2S-format serial PCM receiver: oversamples bck/lrck/adata on scki, deserializes
// MSB-first left/right words and presents one stereo pair per frame with a valid strobe.
module pcm_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic             scki,
   input  logic             rst_n,
   input  logic             bck,
   input  logic             lrck,
   input  logic             adata,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             valid,
   output logic             short_err,
   output logic             locked
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WLAST = CW'(WIDTH - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

   typedef enum logic {IDLE, RUN} state_t;

   logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [SYNC_STAGES-1:0] adata_sync_q, adata_sync_d;
   logic bck_prev_q, bck_prev_d;
   logic bck_rise;

   // Two-stage edge pipeline: detect stage, then capture/boundary stage.
   logic rise_q, rise_d, lrck_p_q, lrck_p_d, adata_p_q, adata_p_d;
   logic cap_rise_q, cap_rise_d, cap_bnd_q, cap_bnd_d;
   logic cap_lrck_q, cap_lrck_d, cap_adata_q, cap_adata_d;
   logic lrck_last_q, lrck_last_d;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d, hold_q, hold_d;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
   logic             left_ok_q, left_ok_d;
   logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
   logic             valid_q, valid_d, short_q, short_d, locked_q, locked_d;
   logic [TW-1:0]    to_q, to_d;
   logic             timeout_hit;
   logic [WIDTH-1:0] word;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      bck_sync_d   = {bck_sync_q[SYNC_STAGES-2:0], bck};
      lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], lrck};
      adata_sync_d = {adata_sync_q[SYNC_STAGES-2:0], adata};
      bck_prev_d   = bck_sync_q[SYNC_STAGES-1];
      bck_rise     = bck_sync_q[SYNC_STAGES-1] & ~bck_prev_q;

      rise_d    = bck_rise;
      lrck_p_d  = lrck_sync_q[SYNC_STAGES-1];
      adata_p_d = adata_sync_q[SYNC_STAGES-1];

      cap_rise_d  = rise_q;
      cap_bnd_d   = rise_q & (lrck_p_q ^ lrck_last_q);
      cap_lrck_d  = cap_lrck_q;
      cap_adata_d = cap_adata_q;
      lrck_last_d = lrck_last_q;
      if (rise_q) begin
         cap_lrck_d  = lrck_p_q;
         cap_adata_d = adata_p_q;
         lrck_last_d = lrck_p_q;
      end

      // A bck rise always wins over timeout expiry in the same cycle.
      to_d        = to_q;
      timeout_hit = 1'b0;
      if (rise_q) begin
         to_d = '0;
      end else if (to_q != TMAX) begin
         to_d        = to_q + TW'(1);
         timeout_hit = (to_q == TLAST);
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      left_ok_d = left_ok_q;
      left_d    = left_q;
      right_d   = right_q;
      valid_d   = 1'b0;
      short_d   = 1'b0;
      locked_d  = locked_q;

      // Word as it stands after writing the current bit; count saturates at WIDTH.
      word    = shreg_q;
      cnt_inc = cnt_q;
      if (cnt_q <= WLAST) begin
         cnt_inc = cnt_q + CW'(1);
         for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(WIDTH - 1 - i)) word[i] = cap_adata_q;
         end
      end

      case (state_q)
         IDLE: begin
            if (cap_rise_q && cap_bnd_q) begin
               state_d   = RUN;
               shreg_d   = '0;
               cnt_d     = '0;
               left_ok_d = 1'b0;
               locked_d  = 1'b1;
            end
         end
         RUN: begin
            if (cap_rise_q && cap_bnd_q) begin
               if (cap_lrck_q) begin
                  hold_d    = word;
                  left_ok_d = 1'b1;
               end else begin
                  if (left_ok_q) begin
                     left_d  = hold_q;
                     right_d = word;
                     valid_d = 1'b1;
                  end
                  left_ok_d = 1'b0;
               end
               short_d = (cnt_q < WLAST);
               shreg_d = '0;
               cnt_d   = '0;
            end else if (cap_rise_q) begin
               shreg_d = word;
               cnt_d   = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         state_d   = IDLE;
         locked_d  = 1'b0;
         left_ok_d = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge scki or negedge rst_n) begin
      if (!rst_n) begin
         bck_sync_q   <= '0;
         lrck_sync_q  <= '0;
         adata_sync_q <= '0;
         bck_prev_q   <= 1'b0;
         rise_q       <= 1'b0;
         lrck_p_q     <= 1'b0;
         adata_p_q    <= 1'b0;
         cap_rise_q   <= 1'b0;
         cap_bnd_q    <= 1'b0;
         cap_lrck_q   <= 1'b0;
         cap_adata_q  <= 1'b0;
         lrck_last_q  <= 1'b0;
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         hold_q       <= '0;
         left_ok_q    <= 1'b0;
         left_q       <= '0;
         right_q      <= '0;
         valid_q      <= 1'b0;
         short_q      <= 1'b0;
         locked_q     <= 1'b0;
         to_q         <= '0;
      end else begin
         bck_sync_q   <= bck_sync_d;
         lrck_sync_q  <= lrck_sync_d;
         adata_sync_q <= adata_sync_d;
         bck_prev_q   <= bck_prev_d;
         rise_q       <= rise_d;
         lrck_p_q     <= lrck_p_d;
         adata_p_q    <= adata_p_d;
         cap_rise_q   <= cap_rise_d;
         cap_bnd_q    <= cap_bnd_d;
         cap_lrck_q   <= cap_lrck_d;
         cap_adata_q  <= cap_adata_d;
         lrck_last_q  <= lrck_last_d;
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         left_ok_q    <= left_ok_d;
         left_q       <= left_d;
         right_q      <= right_d;
         valid_q      <= valid_d;
         short_q      <= short_d;
         locked_q     <= locked_d;
         to_q         <= to_d;
      end
   end

   assign left_data  = left_q;
   assign right_data = right_q;
   assign valid      = valid_q;
   assign short_err  = short_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_pcm_rx.sv
// Directed bench for pcm_rx: drives an I2S stream (lrck leads data by one bit)
// at 8 scki per bck and checks decoded words, strobes, lock and timeout.
module tb_pcm_rx;

   logic        scki = 1'b0;
   logic        rst_n, bck, lrck, adata;
   logic [15:0] left_data, right_data;
   logic        valid, short_err, locked;

   int          n_checks = 0;
   int          n_pass = 0;
   int          valid_cnt = 0;
   int          short_cnt = 0;
   logic [15:0] last_l = '0;
   logic [15:0] last_r = '0;
   logic        prev_d;
   int          vb, sb, lat;

   pcm_rx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(64)) u_dut (
      .scki       (scki),
      .rst_n      (rst_n),
      .bck        (bck),
      .lrck       (lrck),
      .adata      (adata),
      .left_data  (left_data),
      .right_data (right_data),
      .valid      (valid),
      .short_err  (short_err),
      .locked     (locked)
   );

   always #5 scki = ~scki;

   always @(negedge scki) begin
      if (valid === 1'b1) begin
         valid_cnt++;
         last_l = left_data;
         last_r = right_data;
      end
      if (short_err === 1'b1) short_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One bck period; adata carries the bit queued by the previous call (I2S delay).
   task automatic emit(input logic ch, input logic d);
      bck   = 1'b0;
      lrck  = ch;
      adata = prev_d;
      repeat (4) @(negedge scki);
      bck = 1'b1;
      repeat (4) @(negedge scki);
      prev_d = d;
   endtask

   task automatic send_word(input logic ch, input logic [23:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) emit(ch, w[i]);
   endtask

   task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n);
      send_word(1'b0, l, n);
      send_word(1'b1, r, n);
   endtask

   task automatic flush();
      emit(1'b0, 1'b0);
      repeat (4) @(negedge scki);
   endtask

   task automatic do_reset();
      @(negedge scki);
      rst_n  = 1'b0;
      bck    = 1'b0;
      lrck   = 1'b0;
      adata  = 1'b0;
      prev_d = 1'b0;
      repeat (3) @(negedge scki);
      rst_n = 1'b1;
      repeat (2) @(negedge scki);
   endtask

   initial begin
      rst_n = 1'b0; bck = 1'b0; lrck = 1'b0; adata = 1'b0; prev_d = 1'b0;
      repeat (3) @(negedge scki);
      chk("rst_left", 32'(left_data), 32'h0);
      chk("rst_right", 32'(right_data), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_short", 32'(short_err), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);

      // Full 16-bit frames with a right-channel lead-in so the first boundary enters left.
      do_reset();
      vb = valid_cnt; sb = short_cnt;
      send_word(1'b1, 24'h0, 16);
      for (int f = 0; f < 3; f++) send_frame(24'h00A5C3, 24'h001234, 16);
      bck = 1'b0; lrck = 1'b0; adata = prev_d;
      repeat (4) @(negedge scki);
      bck = 1'b1;
      lat = 0;
      while (valid !== 1'b1 && lat < 20) begin
         @(negedge scki);
         lat++;
      end
      chk("t1_latency", 32'(lat), 32'd5);
      @(negedge scki);
      chk("t1_valid_width", 32'(valid), 32'h0);
      repeat (3) @(negedge scki);
      chk("t1_valid_count", 32'(valid_cnt - vb), 32'd3);
      chk("t1_short_count", 32'(short_cnt - sb), 32'd0);
      chk("t1_left", 32'(last_l), 32'h0000A5C3);
      chk("t1_right", 32'(last_r), 32'h00001234);

      // Stream starting mid right channel.
      do_reset();
      vb = valid_cnt;
      chk("t2_locked_before", 32'(locked), 32'h0);
      emit(1'b1, 1'b1);
      repeat (2) @(negedge scki);
      chk("t2_locked_at_first_change", 32'(locked), 32'h1);
      for (int i = 0; i < 6; i++) emit(1'b1, 1'b1);
      send_word(1'b0, 24'h008001, 16);
      chk("t2_no_valid_partial", 32'(valid_cnt - vb), 32'd0);
      send_word(1'b1, 24'h007FFE, 16);
      flush();
      chk("t2_valid_count", 32'(valid_cnt - vb), 32'd1);
      chk("t2_left", 32'(last_l), 32'h00008001);
      chk("t2_right", 32'(last_r), 32'h00007FFE);

      // 12-bit slots: left-justified and zero-filled, short_err on every commit.
      do_reset();
      vb = valid_cnt; sb = short_cnt;
      send_word(1'b1, 24'h0, 16);
      for (int f = 0; f < 2; f++) send_frame(24'h000FFF, 24'h000001, 12);
      flush();
      chk("t3_valid_count", 32'(valid_cnt - vb), 32'd2);
      chk("t3_short_count", 32'(short_cnt - sb), 32'd4);
      chk("t3_left", 32'(last_l), 32'h0000FFF0);
      chk("t3_right", 32'(last_r), 32'h00000010);

      // 24-bit slots: extra LSBs ignored.
      do_reset();
      vb = valid_cnt; sb = short_cnt;
      send_word(1'b1, 24'h0, 16);
      send_frame(24'hABCDEF, 24'h123456, 24);
      flush();
      chk("t4_valid_count", 32'(valid_cnt - vb), 32'd1);
      chk("t4_short_count", 32'(short_cnt - sb), 32'd0);
      chk("t4_left", 32'(last_l), 32'h0000ABCD);
      chk("t4_right", 32'(last_r), 32'h00001234);

      // bck stall mid-word drops lock; outputs hold; relock on restart.
      do_reset();
      vb = valid_cnt;
      send_word(1'b1, 24'h0, 16);
      send_frame(24'h001111, 24'h002222, 16);
      flush();
      for (int i = 15; i > 10; i--) emit(1'b0, 1'b1);
      bck = 1'b0;
      repeat (40) @(negedge scki);
      chk("t5_locked_mid_stall", 32'(locked), 32'h1);
      repeat (30) @(negedge scki);
      chk("t5_unlocked", 32'(locked), 32'h0);
      chk("t5_valid_count_stall", 32'(valid_cnt - vb), 32'd1);
      chk("t5_left_hold", 32'(left_data), 32'h00001111);
      chk("t5_right_hold", 32'(right_data), 32'h00002222);
      vb = valid_cnt;
      send_word(1'b1, 24'h0, 16);
      send_frame(24'h005555, 24'h00AAAA, 16);
      flush();
      chk("t5_relocked", 32'(locked), 32'h1);
      chk("t5_valid_count_restart", 32'(valid_cnt - vb), 32'd1);
      chk("t5_left_restart", 32'(last_l), 32'h00005555);
      chk("t5_right_restart", 32'(last_r), 32'h0000AAAA);

      // Reset mid right word.
      do_reset();
      send_word(1'b1, 24'h0, 16);
      send_frame(24'h001357, 24'h002468, 16);
      send_word(1'b0, 24'h00AAAA, 16);
      for (int i = 15; i > 7; i--) emit(1'b1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_left", 32'(left_data), 32'h0);
      chk("t6_rst_right", 32'(right_data), 32'h0);
      chk("t6_rst_locked", 32'(locked), 32'h0);
      chk("t6_rst_valid", 32'(valid), 32'h0);
      @(negedge scki);
      bck = 1'b0;
      repeat (2) @(negedge scki);
      rst_n = 1'b1;
      repeat (2) @(negedge scki);
      vb = valid_cnt;
      for (int i = 7; i >= 0; i--) emit(1'b1, 1'b1);
      send_word(1'b0, 24'h000F0F, 16);
      chk("t6_no_valid_after_resync", 32'(valid_cnt - vb), 32'd0);
      send_word(1'b1, 24'h00F0F0, 16);
      flush();
      chk("t6_valid_count", 32'(valid_cnt - vb), 32'd1);
      chk("t6_left", 32'(last_l), 32'h00000F0F);
      chk("t6_right", 32'(last_r), 32'h0000F0F0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
